rram_array_model: RTL
=====================

Name: rram_array_model

Overview:
- Parametrised, clocked successor to the RRAM analog behavioural model, for digital-controller simulation and FPGA emulation.
- Holds a multi-level conductance per cell, each stored as an ADC-threshold code.
- Replaces the random, delay-based model with a deterministic, cycle-counted model. Adds configurable read/write latency, a DAC-dependent SET/RST step, a busy/ready handshake, illegal-access error flagging and a pulse counter.
- Sits in place of the analog macro underneath the RRAM controller FSM.

Parameters:
- WORD_SIZE, 48, bits per word.
- NUM_WORDS, 64, words in array.
- ADDR_BITS, 16, address port width.
- ADC_BITS, 6, conductance code width.
- WL_DAC_BITS, 8, wordline DAC config width.
- BSL_DAC_BITS, 5, bitline/sourceline DAC config width.
- READ_LAT, 4, cycles from read accept to sa_rdy (≥1).
- WRITE_LAT, 8, cycles a write pulse occupies the array (≥1).
- DEFAULT_LEVEL, 0, conductance code loaded on reset.
- STEP_SHIFT, 2, right shift applied to bsl_dac_config to form the step.

Ports:
- aclk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- sa_en  in  1  read request level; held high for the whole read.
- we  in  1  write request, sampled only in IDLE.
- rram_addr  in  ADDR_BITS  word address.
- di  in  WORD_SIZE  data/mask input.
- set_rst  in  1  1 = SET, 0 = RST.
- read_ref  in  ADC_BITS  sense threshold.
- wl_dac_config  in  WL_DAC_BITS  wordline pulse amplitude.
- bsl_dac_config  in  BSL_DAC_BITS  BL/SL pulse amplitude.
- sa_do  out  WORD_SIZE  sensed data.
- sa_rdy  out  1  sa_do valid.
- busy  out  1  array not in IDLE.
- err  out  1  sticky illegal-request flag.
- pulse_cnt  out  16  saturating count of applied write pulses.

Behaviour:
- Reset values: all cells = DEFAULT_LEVEL; sa_do = 0; sa_rdy = 0; busy = 0; err = 0; pulse_cnt = 0; FSM = IDLE. Reset wins over any request in the same cycle and aborts any operation in progress with no cell update.
- Cell mask: mask = di XNOR {WORD_SIZE{set_rst}}. It is latched together with addr, set_rst, read_ref and DAC configs at request accept.
- FSM states: IDLE, READ, RDY, WRITE.
- IDLE:
  - sa_en=1 and we=0 and addr<NUM_WORDS → READ, load counter = READ_LAT-1.
  - we=1 and sa_en=0 and addr<NUM_WORDS → WRITE, load counter = WRITE_LAT-1.
  - sa_en=1 and we=1 in the same cycle → err := 1, no operation, stay IDLE.
  - Any request with addr ≥ NUM_WORDS → err := 1, no operation, stay IDLE.
- READ:
  - Counter decrements each cycle.
  - At 0 → RDY, with sa_do[i] = mask[i] ? (g[addr][i] ≥ read_ref) : 0, and sa_rdy = 1 in the same edge.
  - Latency: sa_en accepted at edge N → sa_rdy high after edge N+READ_LAT.
  - sa_en low before completion → IDLE, sa_rdy stays 0, sa_do unchanged.
- RDY:
  - sa_rdy and sa_do hold while sa_en = 1.
  - sa_en = 0 → IDLE on the next edge, with sa_rdy := 0 and sa_do := 0.
  - A new read needs sa_en to pass through 0.
- WRITE:
  - busy = 1. we, sa_en and input changes are ignored; sa_en=1 here sets err.
  - On counter reaching 0, apply the pulse and return to IDLE on the same edge.
  - step = 1 + (bsl_dac_config >> STEP_SHIFT), as an ADC_BITS-wide unsigned value.
  - For each masked cell, when wl_dac_config ≠ 0:
    - SET: g := min(g + step, 2^ADC_BITS − 1).
    - RST: g := max(g − step, 0).
    - Compute in ADC_BITS+1 bits, then saturate.
  - wl_dac_config = 0: no cell change, but the pulse still counts.
  - pulse_cnt increments once per completed write and saturates at 0xFFFF.
  - An aborted write (reset) is not counted.
- busy = (state ≠ IDLE).
- err clears only on rst.
- Cells are never modified by reads.

Test Plan:
- Reset, then read addr 5 with di = all 1s, set_rst = 1, read_ref = 0, READ_LAT = 4 → sa_rdy rises exactly 4 cycles after accept, sa_do = all 1s. Repeat with read_ref = 1 → sa_do = 0.
- SET to addr 3 with di = 0x1 (bit 0 only), bsl = 8, wl = 1 → after 8 busy cycles, g[3][0] = 3, other bits stay 0, pulse_cnt = 1. Read with ref = 3 → sa_do bit 0 = 1; with ref = 4 → 0.
- Saturation: 30 SETs with bsl = 31 (step 8) on bit 0 → g = 63. Then 20 RSTs (di = 0, set_rst = 0) → g = 0, with no wrap in either direction.
- wl_dac_config = 0 write → cells unchanged, pulse_cnt increments.
- Illegal requests set err and leave cells, busy and pulse_cnt unchanged:
  - sa_en and we asserted in the same IDLE cycle.
  - Any request with rram_addr = 64.
  - sa_en raised during WRITE.
- Abort paths:
  - sa_en dropped 2 cycles into a read → sa_rdy never asserts, FSM returns to IDLE.
  - rst asserted mid-WRITE → no cell change, pulse_cnt = 0, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/rram_array_model.sv
// Cycle-counted behavioural model of a multi-level RRAM array. Each cell holds a
// conductance code. It provides latency-accurate read/write, saturating SET/RST steps, error and pulse tracking.
module rram_array_model #(
  parameter int WORD_SIZE     = 48,
  parameter int NUM_WORDS     = 64,
  parameter int ADDR_BITS     = 16,
  parameter int ADC_BITS      = 6,
  parameter int WL_DAC_BITS   = 8,
  parameter int BSL_DAC_BITS  = 5,
  parameter int READ_LAT      = 4,
  parameter int WRITE_LAT     = 8,
  parameter int DEFAULT_LEVEL = 0,
  parameter int STEP_SHIFT    = 2
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    sa_en,
  input  logic                    we,
  input  logic [ADDR_BITS-1:0]    rram_addr,
  input  logic [WORD_SIZE-1:0]    di,
  input  logic                    set_rst,
  input  logic [ADC_BITS-1:0]     read_ref,
  input  logic [WL_DAC_BITS-1:0]  wl_dac_config,
  input  logic [BSL_DAC_BITS-1:0] bsl_dac_config,
  output logic [WORD_SIZE-1:0]    sa_do,
  output logic                    sa_rdy,
  output logic                    busy,
  output logic                    err,
  output logic [15:0]             pulse_cnt
);

  localparam int IDX_BITS = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_BITS = 16;

  typedef enum logic [1:0] {IDLE, READ, RDY, WRITE} state_e;

  state_e                  state_q, state_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic [IDX_BITS-1:0]     addr_q, addr_d;
  logic [WORD_SIZE-1:0]    mask_q, mask_d;
  logic                    set_q, set_d;
  logic [ADC_BITS-1:0]     ref_q, ref_d;
  logic [WL_DAC_BITS-1:0]  wl_q, wl_d;
  logic [BSL_DAC_BITS-1:0] bsl_q, bsl_d;
  logic [WORD_SIZE-1:0]    sa_do_q, sa_do_d;
  logic                    sa_rdy_q, sa_rdy_d;
  logic                    err_q, err_d;
  logic [15:0]             pulse_q, pulse_d;
  logic                    pulse_apply;
  logic                    addr_ok;

  logic [ADC_BITS-1:0]     g_q [NUM_WORDS][WORD_SIZE];
  logic [ADC_BITS-1:0]     word_d [WORD_SIZE];
  logic [WORD_SIZE-1:0]    sensed;
  logic [ADC_BITS-1:0]     step;
  logic [ADC_BITS:0]       sum;

  assign addr_ok = (rram_addr < ADDR_BITS'(NUM_WORDS));
  assign step    = ADC_BITS'(1) + ADC_BITS'(bsl_q >> STEP_SHIFT);

  // Sense result and post-pulse value for the latched word; one extra bit catches over/underflow.
  always_comb begin
    sum    = '0;
    sensed = '0;
    for (int b = 0; b < WORD_SIZE; b++) begin
      word_d[b] = g_q[addr_q][b];
      sensed[b] = mask_q[b] && (g_q[addr_q][b] >= ref_q);
      if (mask_q[b] && (wl_q != '0)) begin
        if (set_q) begin
          sum       = {1'b0, g_q[addr_q][b]} + {1'b0, step};
          word_d[b] = sum[ADC_BITS] ? '1 : sum[ADC_BITS-1:0];
        end else begin
          sum       = {1'b0, g_q[addr_q][b]} - {1'b0, step};
          word_d[b] = sum[ADC_BITS] ? '0 : sum[ADC_BITS-1:0];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    set_d       = set_q;
    ref_d       = ref_q;
    wl_d        = wl_q;
    bsl_d       = bsl_q;
    sa_do_d     = sa_do_q;
    sa_rdy_d    = sa_rdy_q;
    err_d       = err_q;
    pulse_d     = pulse_q;
    pulse_apply = 1'b0;
    case (state_q)
      IDLE: begin
        if (sa_en || we) begin
          if ((sa_en && we) || !addr_ok) begin
            err_d = 1'b1;
          end else begin
            addr_d = rram_addr[IDX_BITS-1:0];
            mask_d = ~(di ^ {WORD_SIZE{set_rst}});
            set_d  = set_rst;
            ref_d  = read_ref;
            wl_d   = wl_dac_config;
            bsl_d  = bsl_dac_config;
            if (sa_en) begin
              state_d = READ;
              cnt_d   = CNT_BITS'(READ_LAT - 1);
            end else begin
              state_d = WRITE;
              cnt_d   = CNT_BITS'(WRITE_LAT - 1);
            end
          end
        end
      end
      READ: begin
        if (!sa_en) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d  = RDY;
          sa_rdy_d = 1'b1;
          sa_do_d  = sensed;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RDY: begin
        if (!sa_en) begin
          state_d  = IDLE;
          sa_rdy_d = 1'b0;
          sa_do_d  = '0;
        end
      end
      WRITE: begin
        if (sa_en) err_d = 1'b1;
        if (cnt_q == '0) begin
          state_d     = IDLE;
          pulse_apply = 1'b1;
          if (pulse_q != 16'hFFFF) pulse_d = pulse_q + 16'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
      set_q    <= 1'b0;
      ref_q    <= '0;
      wl_q     <= '0;
      bsl_q    <= '0;
      sa_do_q  <= '0;
      sa_rdy_q <= 1'b0;
      err_q    <= 1'b0;
      pulse_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      set_q    <= set_d;
      ref_q    <= ref_d;
      wl_q     <= wl_d;
      bsl_q    <= bsl_d;
      sa_do_q  <= sa_do_d;
      sa_rdy_q <= sa_rdy_d;
      err_q    <= err_d;
      pulse_q  <= pulse_d;
    end
  end

  // Reset restores every cell, so an interrupted pulse never reaches the array.
  always_ff @(posedge aclk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WORDS; w++)
        for (int b = 0; b < WORD_SIZE; b++)
          g_q[w][b] <= ADC_BITS'(DEFAULT_LEVEL);
    end else if (pulse_apply) begin
      for (int b = 0; b < WORD_SIZE; b++)
        g_q[addr_q][b] <= word_d[b];
    end
  end

  assign sa_do     = sa_do_q;
  assign sa_rdy    = sa_rdy_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign pulse_cnt = pulse_q;

endmodule
